// File: rtl/led_ripple_bidir_pkg.sv
// Shared constants and types for the bidirectional LED ripple controller.
// Holds the reset pattern, direction and run-state encodings, and the rotate helper.
package led_ripple_bidir_pkg;

    localparam logic [7:0]  LED_RESET_PATTERN   = 8'b0000_0001;
    localparam logic        DIR_UP              = 1'b0;
    localparam logic        DIR_DOWN            = 1'b1;
    localparam int unsigned DEF_SHIFT_TIME      = 32'd50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1_000_000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_e;

    // Circular one-position rotation; up moves led[i] to led[i+1].
    function automatic logic [7:0] rotate_led(input logic [7:0] led_v, input logic dir_v);
        logic [7:0] res;
        case (dir_v)
            DIR_UP:   res = {led_v[6:0], led_v[7]};
            DIR_DOWN: res = {led_v[0], led_v[7:1]};
            default:  res = LED_RESET_PATTERN;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_ripple_bidir_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-count debouncer and a
// single-cycle press pulse on each debounced 0 -> 1 transition.
module btn_debounce
    import led_ripple_bidir_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam int unsigned    SC_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;
    logic            db_d;
    logic [SC_W-1:0] sc_q;
    logic [SC_W-1:0] sc_d;
    logic            press_q;
    logic            press_d;

    // Two-stage synchronizer for the raw asynchronous button.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Stable counter: the debounced state only flips after an unbroken run of
    // DEBOUNCE_CYCLES differing samples; the pulse fires on a press only.
    always_comb begin
        sc_d    = sc_q;
        db_d    = db_q;
        press_d = 1'b0;
        if (sync2_q == db_q) begin
            sc_d = {SC_W{1'b0}};
        end else if (sc_q == SC_LAST) begin
            db_d    = ~db_q;
            sc_d    = {SC_W{1'b0}};
            press_d = ~db_q;
        end else begin
            sc_d = sc_q + SC_W'(1);
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sc_q    <= {SC_W{1'b0}};
            db_q    <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sc_q    <= sc_d;
            db_q    <= db_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_ripple_bidir.sv
// Eight-LED single-dot ripple with debounced direction-toggle and pause-toggle
// buttons; one shift every SHIFT_TIME+1 running cycles.
module led_ripple_bidir
    import led_ripple_bidir_pkg::*;
#(
    parameter int unsigned SHIFT_TIME      = DEF_SHIFT_TIME,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_dir,
    input  logic       btn_pause,
    output logic [7:0] led,
    output logic       dir,
    output logic       paused
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_TIME);

    run_state_e       state_q;
    run_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       led_q;
    logic [7:0]       led_d;
    logic             dir_q;
    logic             dir_d;
    logic             dir_press_s;
    logic             pause_press_s;
    logic             tick_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_dir (
        .clk_i     (clk),
        .rst_i     (reset),
        .btn_raw_i (btn_dir),
        .press_o   (dir_press_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_pause (
        .clk_i     (clk),
        .rst_i     (reset),
        .btn_raw_i (btn_pause),
        .press_o   (pause_press_s)
    );

    assign tick_s = (cnt_q == CNT_LAST);

    // Run/pause FSM, tick counter and rotation. A pause landing on the tick
    // wins: the counter stays parked at its terminal value so the shift fires
    // on the first cycle after resume.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        dir_d   = dir_q;
        case (state_q)
            ST_RUN: begin
                if (pause_press_s) begin
                    state_d = ST_PAUSED;
                    if (tick_s) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tick_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    led_d = rotate_led(led_q, dir_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PAUSED: begin
                if (pause_press_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = {CNT_W{1'b0}};
                led_d   = LED_RESET_PATTERN;
            end
        endcase
        // The rotation above already used the old direction.
        if (dir_press_s) begin
            dir_d = ~dir_q;
        end else begin
            dir_d = dir_q;
        end
    end

    // State registers; outputs come straight from these.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= {CNT_W{1'b0}};
            led_q   <= LED_RESET_PATTERN;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
        end
    end

    assign led    = led_q;
    assign dir    = dir_q;
    assign paused = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_led_ripple_bidir.sv
// Randomized and directed bench for led_ripple_bidir against a position/counter
// reference model driven from raw button sample history.
module tb_led_ripple_bidir;

    localparam int ST = 3;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_pause = 1'b0;
    logic [7:0] led;
    logic       dir;
    logic       paused;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int m_pos, m_cnt, m_edge;
    bit m_dir, m_paused, m_dpulse, m_ppulse, m_ddb, m_pdb;
    bit raw_d[$];
    bit raw_p[$];

    led_ripple_bidir #(
        .SHIFT_TIME      (ST),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_dir   (btn_dir),
        .btn_pause (btn_pause),
        .led       (led),
        .dir       (dir),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    // Synchronized sample seen by the debouncer before edge n (edges count from 1).
    function automatic bit sync_at(input bit sel, input int n);
        if (n < 3) return 1'b0;
        return sel ? raw_p[n-3] : raw_d[n-3];
    endfunction

    // True when the last DB synchronized samples all disagree with db.
    function automatic bit window_differs(input bit sel, input int n, input bit db);
        for (int j = n - DB + 1; j <= n; j++) begin
            if (sync_at(sel, j) == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_cnt = 0; m_edge = 0;
        m_dir = 1'b0; m_paused = 1'b0;
        m_dpulse = 1'b0; m_ppulse = 1'b0; m_ddb = 1'b0; m_pdb = 1'b0;
        raw_d.delete();
        raw_p.delete();
    endtask

    // Advance one clock: update the model for this edge, then compare the DUT.
    task automatic step();
        bit tick, nd, np;
        m_edge++;
        raw_d.push_back(btn_dir);
        raw_p.push_back(btn_pause);
        tick = !m_paused && (m_cnt == ST);
        if (!m_paused) begin
            if (m_ppulse) begin
                m_paused = 1'b1;
                if (!tick) m_cnt++;
            end else if (tick) begin
                m_cnt = 0;
                m_pos = m_dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
            end else begin
                m_cnt++;
            end
        end else if (m_ppulse) begin
            m_paused = 1'b0;
        end
        if (m_dpulse) m_dir = !m_dir;
        nd = window_differs(1'b0, m_edge, m_ddb);
        np = window_differs(1'b1, m_edge, m_pdb);
        m_dpulse = nd && !m_ddb;
        m_ppulse = np && !m_pdb;
        if (nd) m_ddb = !m_ddb;
        if (np) m_pdb = !m_pdb;
        @(posedge clk);
        #1;
        vectors++;
        if (led !== 8'(1 << m_pos)) begin
            errors++;
            $display("FAIL model_led edge %0d: got %02h expected %02h", m_edge, led, 8'(1 << m_pos));
        end
        vectors++;
        if (dir !== m_dir) begin
            errors++;
            $display("FAIL model_dir edge %0d: got %0b expected %0b", m_edge, dir, m_dir);
        end
        vectors++;
        if (paused !== m_paused) begin
            errors++;
            $display("FAIL model_paused edge %0d: got %0b expected %0b", m_edge, paused, m_paused);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_dir = 1'b0;
        btn_pause = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (led !== 8'h01 || dir !== 1'b0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got led=%02h dir=%0b paused=%0b expected 01/0/0", led, dir, paused);
        end
        apply_reset();
    endtask

    task automatic test_ripple();
        apply_reset();
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k % 4 == 0) begin
                vectors++;
                if (led !== 8'(1 << ((k / 4) % 8))) begin
                    errors++;
                    $display("FAIL ripple_up step %0d: got %02h expected %02h", k, led, 8'(1 << ((k / 4) % 8)));
                end
            end
        end
    endtask

    task automatic test_dir_press();
        apply_reset();
        for (int i = 0; i < 50 && m_pos != 2; i++) step();
        vectors++;
        if (m_pos != 2) begin
            errors++;
            $display("FAIL dir_press_setup: timeout waiting for led 04");
        end
        btn_dir = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 7) begin
                vectors++;
                if (dir !== 1'b1) begin
                    errors++;
                    $display("FAIL dir_press_latency: got dir=%0b expected 1 after 7 cycles", dir);
                end
            end
        end
        btn_dir = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_glitch();
        bit dir_before;
        dir_before = m_dir;
        btn_dir = 1'b1;
        repeat (2) step();
        btn_dir = 1'b0;
        repeat (16) step();
        vectors++;
        if (dir !== dir_before) begin
            errors++;
            $display("FAIL glitch_dir: got dir=%0b expected %0b", dir, dir_before);
        end
    endtask

    task automatic test_pause();
        logic [7:0] frozen;
        apply_reset();
        repeat (10) step();
        btn_pause = 1'b1;
        repeat (8) step();
        btn_pause = 1'b0;
        vectors++;
        if (paused !== 1'b1) begin
            errors++;
            $display("FAIL pause_enter: got paused=%0b expected 1", paused);
        end
        frozen = led;
        repeat (12) step();
        vectors++;
        if (led !== frozen) begin
            errors++;
            $display("FAIL pause_frozen: got led=%02h expected %02h", led, frozen);
        end
        btn_pause = 1'b1;
        repeat (8) step();
        btn_pause = 1'b0;
        vectors++;
        if (paused !== 1'b0) begin
            errors++;
            $display("FAIL pause_resume: got paused=%0b expected 0", paused);
        end
        repeat (12) step();
    endtask

    task automatic test_dir_at_tick();
        apply_reset();
        for (int i = 0; i < 60 && !(m_cnt == ST && m_pos == 2); i++) step();
        vectors++;
        if (!(m_cnt == ST && m_pos == 2)) begin
            errors++;
            $display("FAIL dir_tick_setup: timeout waiting for tick at led 04");
        end
        repeat (2) step();
        btn_dir = 1'b1;
        repeat (6) step();
        btn_dir = 1'b0;
        step();
        vectors++;
        if (led !== 8'h20 || dir !== 1'b1) begin
            errors++;
            $display("FAIL dir_tick_old_dir: got led=%02h dir=%0b expected 20/1", led, dir);
        end
        repeat (4) step();
        vectors++;
        if (led !== 8'h10) begin
            errors++;
            $display("FAIL dir_tick_next: got led=%02h expected 10", led);
        end
        repeat (4) step();
        vectors++;
        if (led !== 8'h08) begin
            errors++;
            $display("FAIL dir_tick_next2: got led=%02h expected 08", led);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        btn_dir = 1'b1;
        repeat (6) step();
        btn_dir = 1'b0;
        for (int i = 0; i < 60 && !(m_pos == 7 && m_cnt == 1 && m_dir); i++) step();
        vectors++;
        if (!(m_pos == 7 && m_cnt == 1 && m_dir)) begin
            errors++;
            $display("FAIL async_setup: timeout waiting for led 80 going down");
        end
        btn_pause = 1'b1;
        repeat (8) step();
        btn_pause = 1'b0;
        repeat (3) step();
        vectors++;
        if (led !== 8'h40 || dir !== 1'b1 || paused !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got led=%02h dir=%0b paused=%0b expected 40/1/1", led, dir, paused);
        end
        #3 reset = 1'b1;
        #1;
        vectors++;
        if (led !== 8'h01 || dir !== 1'b0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got led=%02h dir=%0b paused=%0b expected 01/0/0", led, dir, paused);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) step();
        vectors++;
        if (led !== 8'h02) begin
            errors++;
            $display("FAIL async_resume: got led=%02h expected 02", led);
        end
        repeat (8) step();
    endtask

    task automatic test_random();
        int dleft, pleft;
        apply_reset();
        dleft = 0;
        pleft = 0;
        for (int c = 0; c < 1500; c++) begin
            if (dleft == 0) begin
                btn_dir = 1'($urandom_range(0, 1));
                dleft = $urandom_range(1, 12);
            end
            if (pleft == 0) begin
                btn_pause = 1'($urandom_range(0, 1));
                pleft = $urandom_range(1, 12);
            end
            dleft--;
            pleft--;
            step();
        end
        btn_dir = 1'b0;
        btn_pause = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ripple();
        test_dir_press();
        test_glitch();
        test_pause();
        test_dir_at_tick();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
